cnt_modulo_chain: RTL and testbench

- Cascade of STAGES modulo counters sharing one clock, e.g. a seconds/minutes/hours timebase or a BCD display counter.
- Each stage has a run-time programmable modulus.
- Adds up/down counting, synchronous load, synchronous clear, and per-stage carry/borrow ticks.
- Sits between a clock-enable prescaler (drives `ce`) and display/compare logic (consumes `y` and `tick`).

---
 rtl/cnt_modulo_chain_pkg.sv | 18 +
 rtl/cnt_modulo_stage.sv | 59 +++++
 rtl/cnt_modulo_chain.sv | 53 +++++
 tb/tb_cnt_modulo_chain.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cnt_modulo_chain_pkg.sv
// Shared definitions for the cascaded modulo counter: direction encoding and
// the effective-maximum helper used by every stage.
package cnt_modulo_chain_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Widest stage the helper supports; stages narrower than this are cast down.
  localparam int MAXW = 32;

  // M-1 truncated to w bits: a modulus of 0 wraps to 2^w-1, i.e. M = 2^w.
  function automatic logic [MAXW-1:0] eff_max(input logic [MAXW-1:0] m, input int w);
    logic [MAXW-1:0] mask;
    mask = (w >= MAXW) ? {MAXW{1'b1}} : ((MAXW'(1) << w) - MAXW'(1));
    return (m - MAXW'(1)) & mask;
  endfunction

endpackage

// File: rtl/cnt_modulo_stage.sv
// One W-bit modulo stage with up/down counting, synchronous clear/load and a
// terminal flag that feeds the carry chain.
module cnt_modulo_stage
  import cnt_modulo_chain_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cin,
  input  logic         dir,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] mod,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] y,
  output logic         term,
  output logic         cout
);

  logic [W-1:0] y_q;
  logic [W-1:0] y_d;
  logic [W-1:0] max_w;

  assign max_w = W'(eff_max(MAXW'(mod), W));

  // ">=" rather than "==" so a value stranded above a shrunk modulus still wraps.
  assign term = (dir == DIR_DOWN) ? (y_q == '0) : (y_q >= max_w);
  assign cout = cin & term;
  assign y    = y_q;

  always_comb begin
    y_d = y_q;
    if (clr) begin
      y_d = '0;
    end else if (load) begin
      y_d = load_val;
    end else if (cin) begin
      if (dir == DIR_UP) begin
        y_d = term ? '0 : (y_q + W'(1));
      end else if (y_q == '0) begin
        y_d = max_w;
      end else if (y_q > max_w) begin
        y_d = max_w;
      end else begin
        y_d = y_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/cnt_modulo_chain.sv
// Cascade of STAGES programmable modulo counters with a single-cycle carry
// chain; every stage updates on the same edge.
module cnt_modulo_chain
  import cnt_modulo_chain_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  clr,
  input  logic                  load,
  input  logic [STAGES*W-1:0]   load_val,
  input  logic                  dir,
  input  logic [STAGES*W-1:0]   mod,
  output logic [STAGES*W-1:0]   y,
  output logic [STAGES-1:0]     tick,
  output logic                  tc
);

  logic [STAGES:0]   cin;
  logic [STAGES-1:0] term;
  logic [STAGES-1:0] cout;

  // Clear and load are not count steps, so they also suppress every tick.
  assign cin[0] = ce & ~clr & ~load;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      cnt_modulo_stage #(
        .W (W)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .cin      (cin[gi]),
        .dir      (dir),
        .clr      (clr),
        .load     (load),
        .mod      (mod[gi*W +: W]),
        .load_val (load_val[gi*W +: W]),
        .y        (y[gi*W +: W]),
        .term     (term[gi]),
        .cout     (cout[gi])
      );
      assign cin[gi+1] = cout[gi];
      assign tick[gi]  = cout[gi] & ~rst;
    end
  endgenerate

  assign tc = tick[STAGES-1];

endmodule

// File: tb/tb_cnt_modulo_chain.sv
// Scoreboard bench for cnt_modulo_chain: stimulus pushes hand-computed
// expectations, an independent monitor pops and compares them.
module tb_cnt_modulo_chain;

  localparam int STAGES = 3;
  localparam int W      = 4;
  localparam logic [11:0] MOD_STD = 12'hA6A;
  localparam logic [11:0] MOD_OOR = 12'hA65;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        clr;
  logic        load;
  logic [11:0] load_val;
  logic        dir;
  logic [11:0] mod;
  logic [11:0] y;
  logic [2:0]  tick;
  logic        tc;

  typedef struct {
    string       name;
    logic [11:0] y;
    logic [2:0]  tick;
    logic        tc;
  } exp_t;

  exp_t exp_q[$];
  event kick;
  int   checks   = 0;
  int   failures = 0;

  cnt_modulo_chain #(
    .STAGES (STAGES),
    .W      (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .mod      (mod),
    .y        (y),
    .tick     (tick),
    .tc       (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, pending=%0d required=0", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Monitor: compare everything queued whenever outputs are stable.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or kick);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("txn %-14s y=%03h tick=%03b tc=%0b (exp y=%03h tick=%03b tc=%0b)",
                 e.name, y, tick, tc, e.y, e.tick, e.tc);
        checks++;
        if (y !== e.y) begin
          failures++;
          $display("FAIL %s y: got %03h required %03h", e.name, y, e.y);
        end
        checks++;
        if (tick !== e.tick) begin
          failures++;
          $display("FAIL %s tick: got %03b required %03b", e.name, tick, e.tick);
        end
        checks++;
        if (tc !== e.tc) begin
          failures++;
          $display("FAIL %s tc: got %0b required %0b", e.name, tc, e.tc);
        end
      end
    end
  end

  task automatic push(input string nm, input logic [11:0] ey, input logic [2:0] et);
    exp_t e;
    e.name = nm;
    e.y    = ey;
    e.tick = et;
    e.tc   = et[2];
    exp_q.push_back(e);
  endtask

  // One cycle: after the edge, drive inputs for the next edge, then queue the
  // expected count (from the past edge) and tick (for the new inputs).
  task automatic cyc(input string nm, input bit ce_v, input bit clr_v, input bit load_v,
                     input bit dir_v, input logic [11:0] lv, input logic [11:0] mv,
                     input logic [11:0] ey, input logic [2:0] et);
    @(posedge clk);
    #1;
    ce       = ce_v;
    clr      = clr_v;
    load     = load_v;
    dir      = dir_v;
    load_val = lv;
    mod      = mv;
    push(nm, ey, et);
  endtask

  function automatic logic [11:0] cnt_y(input int c);
    return {4'(c / 60), 4'((c / 10) % 6), 4'(c % 10)};
  endfunction

  initial begin
    logic [2:0] et;
    rst = 1'b1; ce = 1'b0; clr = 1'b0; load = 1'b0;
    dir = 1'b0; load_val = '0; mod = MOD_STD;
    #2;
    push("reset", 12'h000, 3'b000);
    -> kick;

    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ce  = 1'b1;
    push("count0", 12'h000, 3'b000);

    for (int i = 1; i <= 60; i++) begin
      et = 3'b000;
      if (i < 60) begin
        et[0] = (i % 10 == 9);
        et[1] = et[0] && ((i / 10) % 6 == 5);
      end
      cyc($sformatf("count%0d", i), (i < 60), 1'b0, 1'b0, 1'b0, 12'h000, MOD_STD, cnt_y(i), et);
    end

    cyc("hold60",        1'b0, 1'b0, 1'b1, 1'b0, 12'h959, MOD_STD, 12'h100, 3'b000);
    cyc("full_up_pre",   1'b1, 1'b0, 1'b0, 1'b0, 12'h959, MOD_STD, 12'h959, 3'b111);
    cyc("full_up_wrap",  1'b0, 1'b0, 1'b0, 1'b0, 12'h000, MOD_STD, 12'h000, 3'b000);
    cyc("full_dn_pre",   1'b1, 1'b0, 1'b0, 1'b1, 12'h000, MOD_STD, 12'h000, 3'b111);
    cyc("full_dn_wrap",  1'b0, 1'b0, 1'b0, 1'b0, 12'h000, MOD_STD, 12'h959, 3'b000);
    cyc("load_ce_pre",   1'b1, 1'b0, 1'b1, 1'b0, 12'h123, MOD_STD, 12'h959, 3'b000);
    cyc("load_ce_post",  1'b1, 1'b1, 1'b1, 1'b0, 12'h456, MOD_STD, 12'h123, 3'b000);
    cyc("clr_load",      1'b0, 1'b0, 1'b1, 1'b0, 12'h345, MOD_STD, 12'h000, 3'b000);
    cyc("load345",       1'b0, 1'b0, 1'b0, 1'b0, 12'h000, MOD_STD, 12'h345, 3'b000);
    for (int i = 1; i <= 4; i++) begin
      cyc($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, MOD_STD, 12'h345, 3'b000);
    end
    cyc("hold5",         1'b0, 1'b0, 1'b1, 1'b0, 12'h128, MOD_STD, 12'h345, 3'b000);
    cyc("oor_up_pre",    1'b1, 1'b0, 1'b0, 1'b0, 12'h000, MOD_OOR, 12'h128, 3'b001);
    cyc("oor_up_post",   1'b0, 1'b0, 1'b1, 1'b0, 12'h128, MOD_OOR, 12'h130, 3'b000);
    cyc("oor_dn_pre",    1'b1, 1'b0, 1'b0, 1'b1, 12'h000, MOD_OOR, 12'h128, 3'b000);
    cyc("oor_dn_post",   1'b1, 1'b0, 1'b0, 1'b0, 12'h000, MOD_STD, 12'h124, 3'b000);
    cyc("resume",        1'b1, 1'b0, 1'b0, 1'b0, 12'h000, MOD_STD, 12'h125, 3'b000);

    // Mid-cycle reset while counting down from a non-zero value.
    @(negedge clk);
    #1;
    dir = 1'b1;
    rst = 1'b1;
    #1;
    push("async_rst", 12'h000, 3'b000);
    -> kick;

    @(posedge clk);
    @(negedge clk);
    #1;
    push("rst_held", 12'h000, 3'b000);
    -> kick;
    #1;
    rst = 1'b0;
    dir = 1'b0;
    cyc("after_rst1",    1'b1, 1'b0, 1'b0, 1'b0, 12'h000, MOD_STD, 12'h001, 3'b000);
    cyc("after_rst2",    1'b0, 1'b0, 1'b0, 1'b0, 12'h000, MOD_STD, 12'h002, 3'b000);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
